// File: rtl/fpu_align_arb.sv
// Round-robin arbiter in front of a shared iterative exponent-alignment unit.
// Two requesters hand in operand pairs; the aligned pair comes back tagged with its owner.
module fpu_align_arb #(
  parameter int EW        = 10,
  parameter int MW        = 27,
  parameter int MAX_SHIFT = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rq0_valid,
  output logic          rq0_ready,
  input  logic [EW-1:0] rq0_ae,
  input  logic [EW-1:0] rq0_be,
  input  logic [MW-1:0] rq0_am,
  input  logic [MW-1:0] rq0_bm,
  input  logic          rq1_valid,
  output logic          rq1_ready,
  input  logic [EW-1:0] rq1_ae,
  input  logic [EW-1:0] rq1_be,
  input  logic [MW-1:0] rq1_am,
  input  logic [MW-1:0] rq1_bm,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_id,
  output logic [EW-1:0] res_e,
  output logic [MW-1:0] res_am,
  output logic [MW-1:0] res_bm,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

  localparam logic [EW:0] MAX_D = (EW+1)'(MAX_SHIFT);

  state_t        state, state_nx;
  logic          ptr;
  logic          id;
  logic [EW-1:0] a_e, b_e;
  logic [MW-1:0] a_m, b_m;
  logic          grant0, grant1;
  logic          accept0, accept1;

  logic signed [EW:0] diff;
  logic        [EW:0] abs_diff;
  logic               a_small;
  logic               clamp;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!ptr) begin
      grant0 = rq0_valid;
      grant1 = !rq0_valid && rq1_valid;
    end else begin
      grant1 = rq1_valid;
      grant0 = !rq1_valid && rq0_valid;
    end
  end

  assign rq0_ready = !rst && (state == IDLE) && grant0;
  assign rq1_ready = !rst && (state == IDLE) && grant1;
  assign accept0   = rq0_valid && rq0_ready;
  assign accept1   = rq1_valid && rq1_ready;

  // Sign-extend by one bit so the extreme exponents cannot overflow the difference.
  assign diff     = $signed({a_e[EW-1], a_e}) - $signed({b_e[EW-1], b_e});
  assign abs_diff = diff[EW] ? (EW+1)'(-diff) : (EW+1)'(diff);
  assign a_small  = diff[EW];
  assign clamp    = abs_diff > MAX_D;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept0 || accept1) state_nx = ALIGN;
      ALIGN:   if (diff == '0 || clamp) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it is just the first branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments to avoid evaluation-order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
      id  <= 1'b0;
      a_e <= '0;
      b_e <= '0;
      a_m <= '0;
      b_m <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept0) begin
            a_e <= rq0_ae;
            b_e <= rq0_be;
            a_m <= rq0_am;
            b_m <= rq0_bm;
            id  <= 1'b0;
            ptr <= 1'b1;
          end else if (accept1) begin
            a_e <= rq1_ae;
            b_e <= rq1_be;
            a_m <= rq1_am;
            b_m <= rq1_bm;
            id  <= 1'b1;
            ptr <= 1'b0;
          end
        end
        ALIGN: begin
          if (diff != '0) begin
            if (clamp) begin
              // Everything shifts out: only the sticky bit survives.
              if (a_small) begin
                a_m <= {{(MW-1){1'b0}}, |a_m};
                a_e <= b_e;
              end else begin
                b_m <= {{(MW-1){1'b0}}, |b_m};
                b_e <= a_e;
              end
            end else if (a_small) begin
              a_m <= {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
              a_e <= a_e + EW'(1);
            end else begin
              b_m <= {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
              b_e <= b_e + EW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_id    = id;
  assign res_e     = a_e;
  assign res_am    = a_m;
  assign res_bm    = b_m;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fpu_align_arb.sv
// Randomized self-checking bench for fpu_align_arb against a closed-form alignment model.
module tb_fpu_align_arb;
  localparam int EW = 10, MW = 27, MAX_SHIFT = 26;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rq0_valid = 1'b0, rq1_valid = 1'b0;
  logic          rq0_ready, rq1_ready;
  logic [EW-1:0] op_ae [2];
  logic [EW-1:0] op_be [2];
  logic [MW-1:0] op_am [2];
  logic [MW-1:0] op_bm [2];
  logic          res_valid, res_id, busy;
  logic          res_ready = 1'b0;
  logic [EW-1:0] res_e;
  logic [MW-1:0] res_am, res_bm;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int acc_wait;
  bit m_ptr;
  logic [EW-1:0] cap_e;
  logic [MW-1:0] cap_am, cap_bm;

  fpu_align_arb #(.EW(EW), .MW(MW), .MAX_SHIFT(MAX_SHIFT)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready),
    .rq0_ae(op_ae[0]), .rq0_be(op_be[0]), .rq0_am(op_am[0]), .rq0_bm(op_bm[0]),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready),
    .rq1_ae(op_ae[1]), .rq1_be(op_be[1]), .rq1_am(op_am[1]), .rq1_bm(op_bm[1]),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_e(res_e), .res_am(res_am), .res_bm(res_bm), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Shifting right by n with sticky: bits above n move down, bits 0..n OR into bit 0.
  function automatic longint sticky_shift(input longint m, input int n);
    longint low_mask;
    low_mask = (64'd1 << (n + 1)) - 1;
    return (m >> n) | longint'((m & low_mask) != 0);
  endfunction

  task automatic model(input bit g, output logic [EW-1:0] e,
                       output logic [MW-1:0] am, output logic [MW-1:0] bm, output int lat);
    int a, b, d, ad;
    longint ma, mb;
    a  = int'($signed(op_ae[g]));
    b  = int'($signed(op_be[g]));
    ma = longint'(op_am[g]);
    mb = longint'(op_bm[g]);
    d  = a - b;
    ad = (d < 0) ? -d : d;
    if (d == 0) begin
      lat = 2;
    end else if (ad > MAX_SHIFT) begin
      lat = 2;
      if (d < 0) ma = longint'(ma != 0);
      else       mb = longint'(mb != 0);
    end else begin
      lat = 2 + ad;
      if (d < 0) ma = sticky_shift(ma, ad);
      else       mb = sticky_shift(mb, ad);
    end
    e  = EW'((a > b) ? a : b);
    am = ma[MW-1:0];
    bm = mb[MW-1:0];
  endtask

  task automatic run_job(input bit v0, input bit v1, input int hold);
    bit g;
    logic [EW-1:0] xe;
    logic [MW-1:0] xam, xbm;
    int lat, n0, w;
    rq0_valid = v0;
    rq1_valid = v1;
    res_ready = 1'b0;
    #1;
    g = m_ptr ? (v1 ? 1'b1 : 1'b0) : (v0 ? 1'b0 : 1'b1);
    w = 0;
    while (!(rq0_ready || rq1_ready) && w < 4) begin
      step();
      w++;
    end
    acc_wait = w;
    nvec++;
    if (rq0_ready !== (g == 1'b0) || rq1_ready !== (g == 1'b1)) begin
      $display("FAIL grant: got ready0=%b ready1=%b, want grant=%0d", rq0_ready, rq1_ready, g);
      nerr++;
      return;
    end
    model(g, xe, xam, xbm, lat);
    n0 = cyc;
    m_ptr = ~g;
    step();
    w = 0;
    while (res_valid !== 1'b1 && w < 60) begin
      nvec++;
      if (busy !== 1'b1 || rq0_ready !== 1'b0 || rq1_ready !== 1'b0) begin
        $display("FAIL busy_no_ready: got busy=%b ready0=%b ready1=%b, want 1 0 0",
                 busy, rq0_ready, rq1_ready);
        nerr++;
      end
      step();
      w++;
    end
    nvec++;
    if (res_valid !== 1'b1) begin
      $display("FAIL result_timeout: got res_valid=%b after %0d cycles, want 1", res_valid, w);
      nerr++;
      return;
    end
    nvec++;
    if (cyc - n0 != lat) begin
      $display("FAIL latency: got %0d cycles, want %0d", cyc - n0, lat);
      nerr++;
    end
    nvec++;
    if ({res_id, res_e, res_am, res_bm} !== {g, xe, xam, xbm} || busy !== 1'b1) begin
      $display("FAIL result: got id=%0d e=%h am=%h bm=%h busy=%b, want id=%0d e=%h am=%h bm=%h busy=1",
               res_id, res_e, res_am, res_bm, busy, g, xe, xam, xbm);
      nerr++;
    end
    cap_e  = res_e;
    cap_am = res_am;
    cap_bm = res_bm;
    repeat (hold) begin
      step();
      nvec++;
      if (res_valid !== 1'b1 || {res_id, res_e, res_am, res_bm} !== {g, xe, xam, xbm} ||
          rq0_ready !== 1'b0 || rq1_ready !== 1'b0) begin
        $display("FAIL hold: got valid=%b id=%0d e=%h am=%h bm=%h r0=%b r1=%b, want held result, readys 0",
                 res_valid, res_id, res_e, res_am, res_bm, rq0_ready, rq1_ready);
        nerr++;
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    nvec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL release: got res_valid=%b busy=%b, want 0 0", res_valid, busy);
      nerr++;
    end
  endtask

  task automatic set_op(input bit r, input logic [EW-1:0] ae, input logic [EW-1:0] be,
                        input logic [MW-1:0] am, input logic [MW-1:0] bm);
    op_ae[r] = ae;
    op_be[r] = be;
    op_am[r] = am;
    op_bm[r] = bm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rq0_valid = 1'b1;
    rq1_valid = 1'b1;
    repeat (2) step();
    nvec++;
    if ({res_valid, res_id, res_e, res_am, res_bm, busy, rq0_ready, rq1_ready} !== '0) begin
      $display("FAIL reset: got valid=%b id=%b e=%h am=%h bm=%h busy=%b r0=%b r1=%b, want all 0",
               res_valid, res_id, res_e, res_am, res_bm, busy, rq0_ready, rq1_ready);
      nerr++;
    end
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    rst = 1'b0;
    m_ptr = 1'b0;
    step();
  endtask

  task automatic test_shift_basic();
    set_op(0, 10'd5, 10'd2, 27'h4000000, 27'h0000007);
    run_job(1'b1, 1'b0, 0);
    rq0_valid = 1'b0;
    nvec++;
    if (cap_e !== 10'd5 || cap_am !== 27'h4000000 || cap_bm !== 27'h0000001) begin
      $display("FAIL shift_basic: got e=%h am=%h bm=%h, want 005 4000000 0000001", cap_e, cap_am, cap_bm);
      nerr++;
    end
  endtask

  task automatic test_equal();
    set_op(1, 10'h3FD, 10'h3FD, 27'h123, 27'h456);
    run_job(1'b0, 1'b1, 0);
    rq1_valid = 1'b0;
    nvec++;
    if (cap_e !== 10'h3FD || cap_am !== 27'h123 || cap_bm !== 27'h456) begin
      $display("FAIL equal: got e=%h am=%h bm=%h, want 3fd 0000123 0000456", cap_e, cap_am, cap_bm);
      nerr++;
    end
  endtask

  task automatic test_clamp();
    set_op(0, 10'h39C, 10'd100, 27'h0000010, 27'h7FFFFFF);
    run_job(1'b1, 1'b0, 0);
    nvec++;
    if (cap_e !== 10'd100 || cap_am !== 27'h0000001 || cap_bm !== 27'h7FFFFFF) begin
      $display("FAIL clamp: got e=%h am=%h bm=%h, want 064 0000001 7ffffff", cap_e, cap_am, cap_bm);
      nerr++;
    end
    set_op(0, 10'h200, 10'h1FF, 27'h5A5A5A5, 27'h0000003);
    run_job(1'b1, 1'b0, 0);
    rq0_valid = 1'b0;
    nvec++;
    if (cap_e !== 10'h1FF || cap_am !== 27'h0000001) begin
      $display("FAIL extremes: got e=%h am=%h, want 1ff 0000001", cap_e, cap_am);
      nerr++;
    end
  endtask

  task automatic test_fairness();
    set_op(0, 10'd7, 10'd3, 27'h00000F0, 27'h1234567);
    set_op(1, 10'd1, 10'd9, 27'h7654321, 27'h0000100);
    for (int k = 0; k < 4; k++) run_job(1'b1, 1'b1, 0);
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
  endtask

  task automatic test_hold();
    set_op(0, 10'd12, 10'd4, 27'h3333333, 27'h00000FF);
    set_op(1, 10'd0, 10'd2, 27'h0000007, 27'h2222222);
    run_job(1'b1, 1'b1, 10);
    run_job(1'b0, 1'b1, 0);
    nvec++;
    if (acc_wait != 0) begin
      $display("FAIL hold_regrant: got grant after %0d cycles, want 0", acc_wait);
      nerr++;
    end
    rq1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    set_op(0, 10'd20, 10'd0, 27'h1FFFFFF, 27'h0ABCDEF);
    rq0_valid = 1'b1;
    rq1_valid = 1'b0;
    #1;
    w = 0;
    while (rq0_ready !== 1'b1 && w < 4) begin
      step();
      w++;
    end
    nvec++;
    if (rq0_ready !== 1'b1) begin
      $display("FAIL reset_mid_accept: got rq0_ready=%b, want 1", rq0_ready);
      nerr++;
    end
    step();
    rq0_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    nvec++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || rq0_ready !== 1'b0 || rq1_ready !== 1'b0) begin
      $display("FAIL reset_mid: got busy=%b res_valid=%b r0=%b r1=%b, want 0 0 0 0",
               busy, res_valid, rq0_ready, rq1_ready);
      nerr++;
    end
    rst = 1'b0;
    m_ptr = 1'b0;
    set_op(1, 10'h3F0, 10'h3F8, 27'h00000AA, 27'h5555555);
    run_job(1'b1, 1'b1, 0);
    run_job(1'b0, 1'b1, 0);
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
  endtask

  task automatic test_random();
    int pat, off;
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 2; r++) begin
        op_ae[r] = EW'($urandom_range(0, 1023));
        off = (k % 5 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 70)) - 35;
        op_be[r] = op_ae[r] + EW'(off);
        op_am[r] = MW'($urandom);
        op_bm[r] = MW'($urandom);
      end
      pat = int'($urandom_range(1, 3));
      run_job(pat[0], pat[1], int'($urandom_range(0, 2)));
    end
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
  endtask

  initial begin
    set_op(0, '0, '0, '0, '0);
    set_op(1, '0, '0, '0, '0);
    test_reset();
    test_shift_basic();
    test_equal();
    test_clamp();
    test_fairness();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
